// File: rtl/ioctl_packer.sv
// HPS ioctl download packer: assembles IN_W ioctl writes into OUT_W memory words
// and queues them through a small FIFO to a one-outstanding req/done write port.
module ioctl_packer #(
    parameter int unsigned IN_W   = 16,
    parameter int unsigned OUT_W  = 32,
    parameter int unsigned ADDR_W = 27,
    parameter int unsigned DEPTH  = 4
) (
    input  logic                clk1x,
    input  logic                reset,
    input  logic                ioctl_download,
    input  logic [7:0]          ioctl_index,
    input  logic [ADDR_W-1:0]   ioctl_addr,
    input  logic [IN_W-1:0]     ioctl_dout,
    input  logic                ioctl_wr,
    output logic                ioctl_wait,
    input  logic [7:0]          cfg_index,
    input  logic [ADDR_W-1:0]   cfg_base,
    input  logic [1:0]          cfg_swap,
    output logic                wr_req,
    output logic [ADDR_W-1:0]   wr_addr,
    output logic [OUT_W-1:0]    wr_data,
    output logic [OUT_W/8-1:0]  wr_be,
    input  logic                wr_done,
    output logic                active,
    output logic                busy,
    output logic                loaded
);
    localparam int unsigned R      = OUT_W / IN_W;
    localparam int unsigned NB_IN  = IN_W / 8;
    localparam int unsigned NB_OUT = OUT_W / 8;
    localparam int unsigned IN_LSB = $clog2(NB_IN);
    localparam int unsigned LANE_W = (R > 1) ? $clog2(R) : 1;
    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned CNT_W  = $clog2(DEPTH + 1);
    localparam logic [ADDR_W-1:0] KEY_MASK = ~ADDR_W'(NB_OUT - 1);

    logic [LANE_W-1:0] lane;
    logic              lane_last;
    logic              wr_ok;
    logic [ADDR_W-1:0] wr_key;
    logic [IN_W-1:0]   din_sw;
    logic [OUT_W-1:0]  lane_data, lane_dmask;
    logic [NB_OUT-1:0] lane_be;

    logic              asm_valid, asm_valid_n;
    logic [ADDR_W-1:0] asm_key, asm_key_n;
    logic [OUT_W-1:0]  asm_data, asm_data_n;
    logic [NB_OUT-1:0] asm_be, asm_be_n;
    logic              defer, defer_n;

    logic              push;
    logic [ADDR_W-1:0] push_key;
    logic [OUT_W-1:0]  push_data;
    logic [NB_OUT-1:0] push_be;
    logic [ADDR_W-1:0] fifo_addr_in;
    logic [OUT_W-1:0]  fifo_data_in;
    logic [NB_OUT-1:0] fifo_be_in;

    logic [ADDR_W-1:0] fifo_addr [DEPTH];
    logic [OUT_W-1:0]  fifo_data [DEPTH];
    logic [NB_OUT-1:0] fifo_be   [DEPTH];
    logic [PTR_W-1:0]  wptr, rptr;
    logic [CNT_W-1:0]  count, count_n;
    logic              pop, fifo_we;
    logic              outstanding, outstanding_n;
    logic              match;

    assign match     = ioctl_download && (ioctl_index == cfg_index);
    assign wr_ok     = ioctl_wr && active;
    assign wr_key    = ioctl_addr & KEY_MASK;
    assign lane      = LANE_W'(ioctl_addr >> IN_LSB) & LANE_W'(R - 1);
    assign lane_last = (lane == LANE_W'(R - 1));

    // Byte swap within the incoming lane and placement into its word slot
    always_comb begin
        din_sw = ioctl_dout;
        if (cfg_swap[0]) begin
            for (int b = 0; b < NB_IN; b++) begin
                din_sw[8*b +: 8] = ioctl_dout[8*(NB_IN-1-b) +: 8];
            end
        end
        lane_data  = '0;
        lane_dmask = '0;
        lane_be    = '0;
        for (int l = 0; l < R; l++) begin
            if (lane == LANE_W'(l)) begin
                lane_data[IN_W*l +: IN_W]   = din_sw;
                lane_dmask[IN_W*l +: IN_W]  = '1;
                lane_be[NB_IN*l +: NB_IN]   = '1;
            end
        end
    end

    // Assembly next state and push decision; at most one push per cycle
    always_comb begin
        asm_valid_n = asm_valid;
        asm_key_n   = asm_key;
        asm_data_n  = asm_data;
        asm_be_n    = asm_be;
        defer_n     = 1'b0;
        push        = 1'b0;
        push_key    = asm_key;
        push_data   = asm_data;
        push_be     = asm_be;
        if (defer || (wr_ok && asm_valid && (wr_key != asm_key))) begin
            // Deferred word or key change: flush held word, restart from new lane
            push        = 1'b1;
            asm_valid_n = 1'b0;
            asm_data_n  = '0;
            asm_be_n    = '0;
            if (wr_ok) begin
                asm_valid_n = 1'b1;
                asm_key_n   = wr_key;
                asm_data_n  = lane_data;
                asm_be_n    = lane_be;
                defer_n     = lane_last;
            end
        end else if (wr_ok) begin
            if (lane_last) begin
                push        = 1'b1;
                push_key    = wr_key;
                push_data   = (asm_data & ~lane_dmask) | lane_data;
                push_be     = asm_be | lane_be;
                asm_valid_n = 1'b0;
                asm_data_n  = '0;
                asm_be_n    = '0;
            end else begin
                asm_valid_n = 1'b1;
                asm_key_n   = wr_key;
                asm_data_n  = (asm_data & ~lane_dmask) | lane_data;
                asm_be_n    = asm_be | lane_be;
            end
        end else if (!active && asm_valid) begin
            push        = 1'b1;
            asm_valid_n = 1'b0;
            asm_data_n  = '0;
            asm_be_n    = '0;
        end
    end

    // FIFO entry formatting (base offset, optional lane reversal) and drain control
    always_comb begin
        fifo_addr_in = cfg_base + push_key;
        fifo_data_in = push_data;
        fifo_be_in   = push_be;
        if (cfg_swap[1]) begin
            for (int l = 0; l < R; l++) begin
                fifo_data_in[IN_W*l +: IN_W] = push_data[IN_W*(R-1-l) +: IN_W];
                fifo_be_in[NB_IN*l +: NB_IN] = push_be[NB_IN*(R-1-l) +: NB_IN];
            end
        end
        pop           = (count != '0) && (!outstanding || wr_done);
        fifo_we       = push && ((count != CNT_W'(DEPTH)) || pop);
        outstanding_n = pop || (outstanding && !wr_done);
        count_n       = count + CNT_W'(fifo_we) - CNT_W'(pop);
    end

    always_ff @(posedge clk1x) begin
        if (reset) begin
            active      <= 1'b0;
            loaded      <= 1'b0;
            asm_valid   <= 1'b0;
            asm_key     <= '0;
            asm_data    <= '0;
            asm_be      <= '0;
            defer       <= 1'b0;
            wptr        <= '0;
            rptr        <= '0;
            count       <= '0;
            outstanding <= 1'b0;
            wr_req      <= 1'b0;
            wr_addr     <= '0;
            wr_data     <= '0;
            wr_be       <= '0;
            ioctl_wait  <= 1'b0;
            busy        <= 1'b0;
        end else begin
            active      <= match;
            loaded      <= loaded || match;
            asm_valid   <= asm_valid_n;
            asm_key     <= asm_key_n;
            asm_data    <= asm_data_n;
            asm_be      <= asm_be_n;
            defer       <= defer_n;
            count       <= count_n;
            outstanding <= outstanding_n;
            if (fifo_we) wptr <= wptr + PTR_W'(1);
            if (pop) begin
                rptr    <= rptr + PTR_W'(1);
                wr_addr <= fifo_addr[rptr];
                wr_data <= fifo_data[rptr];
                wr_be   <= fifo_be[rptr];
            end
            wr_req      <= pop;
            ioctl_wait  <= (count_n >= CNT_W'(DEPTH - 1)) || defer_n;
            busy        <= asm_valid_n || (count_n != '0) || outstanding_n || defer_n;
        end
    end

    // FIFO storage needs no reset; occupancy is tracked by count/pointers
    always_ff @(posedge clk1x) begin
        if (fifo_we) begin
            fifo_addr[wptr] <= fifo_addr_in;
            fifo_data[wptr] <= fifo_data_in;
            fifo_be[wptr]   <= fifo_be_in;
        end
    end
endmodule

// File: tb/tb_ioctl_packer.sv
// Scoreboard bench for ioctl_packer: expected memory writes are queued as ioctl
// stimulus is driven and compared as wr_req pulses appear.
module tb_ioctl_packer;
    localparam int unsigned IN_W   = 16;
    localparam int unsigned OUT_W  = 32;
    localparam int unsigned ADDR_W = 27;
    localparam int unsigned DEPTH  = 4;

    typedef struct packed {
        logic [ADDR_W-1:0]  addr;
        logic [OUT_W-1:0]   data;
        logic [OUT_W/8-1:0] be;
    } wr_t;

    logic               clk1x, reset;
    logic               ioctl_download, ioctl_wr, ioctl_wait;
    logic [7:0]         ioctl_index, cfg_index;
    logic [ADDR_W-1:0]  ioctl_addr, cfg_base, wr_addr;
    logic [IN_W-1:0]    ioctl_dout;
    logic [1:0]         cfg_swap;
    logic               wr_req, wr_done, active, busy, loaded;
    logic [OUT_W-1:0]   wr_data;
    logic [OUT_W/8-1:0] wr_be;

    ioctl_packer #(.IN_W(IN_W), .OUT_W(OUT_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk1x(clk1x), .reset(reset),
        .ioctl_download(ioctl_download), .ioctl_index(ioctl_index),
        .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .ioctl_wr(ioctl_wr),
        .ioctl_wait(ioctl_wait), .cfg_index(cfg_index), .cfg_base(cfg_base),
        .cfg_swap(cfg_swap), .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_be(wr_be), .wr_done(wr_done), .active(active), .busy(busy), .loaded(loaded)
    );

    wr_t sb[$];
    wr_t exp_w;
    int  n_checks = 0, n_errors = 0;
    int  cyc = 0, req_cyc = 0, wr_cyc = 0, n_req = 0;
    int  done_dly = 0, dly_cnt = 0;
    bit  hold = 1'b0, pend = 1'b0, wait_seen = 1'b0;

    initial begin
        clk1x = 1'b0;
        forever #5 clk1x = ~clk1x;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: run exceeded time limit");
        $fatal(1, "watchdog");
    end

    always @(posedge clk1x) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic wr_t mk(input logic [ADDR_W-1:0] a, input logic [OUT_W-1:0] d,
                               input logic [OUT_W/8-1:0] b);
        wr_t w;
        w.addr = a;
        w.data = d;
        w.be   = b;
        return w;
    endfunction

    function automatic logic [31:0] model(input logic [15:0] lo, input logic [15:0] hi,
                                          input logic [1:0] sw);
        logic [15:0] l, h;
        l = sw[0] ? {lo[7:0], lo[15:8]} : lo;
        h = sw[0] ? {hi[7:0], hi[15:8]} : hi;
        return sw[1] ? {l, h} : {h, l};
    endfunction

    // Memory-port monitor: every wr_req must match the head of the scoreboard
    always @(negedge clk1x) begin
        if (ioctl_wait) wait_seen = 1'b1;
        if (wr_req) begin
            n_req++;
            req_cyc = cyc;
            pend    = 1'b1;
            check("req_expected", 64'(sb.size() != 0), 64'(1));
            if (sb.size() != 0) begin
                exp_w = sb.pop_front();
                check("wr_addr", 64'(wr_addr), 64'(exp_w.addr));
                check("wr_data", 64'(wr_data), 64'(exp_w.data));
                check("wr_be",   64'(wr_be),   64'(exp_w.be));
            end
        end
    end

    // Memory-port responder: one-cycle wr_done after done_dly cycles unless held
    initial begin
        wr_done = 1'b0;
        forever begin
            @(posedge clk1x);
            #1;
            wr_done = 1'b0;
            if (pend && !hold) begin
                if (dly_cnt >= done_dly) begin
                    wr_done = 1'b1;
                    pend    = 1'b0;
                    dly_cnt = 0;
                end else begin
                    dly_cnt++;
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk1x);
        #1;
    endtask

    task automatic io_wr(input logic [ADDR_W-1:0] a, input logic [IN_W-1:0] d);
        int g = 0;
        while (ioctl_wait && g < 500) begin
            @(posedge clk1x);
            #1;
            g++;
        end
        if (g >= 500) check("wait_release", 64'(ioctl_wait), 64'(0));
        ioctl_addr = a;
        ioctl_dout = d;
        ioctl_wr   = 1'b1;
        wr_cyc     = cyc;
        @(posedge clk1x);
        #1;
        ioctl_wr = 1'b0;
    endtask

    task automatic write_pair(input logic [ADDR_W-1:0] a, input logic [15:0] lo,
                              input logic [15:0] hi);
        io_wr(a, lo);
        io_wr(a + ADDR_W'(2), hi);
        sb.push_back(mk(cfg_base + a, model(lo, hi, cfg_swap), 4'hF));
    endtask

    task automatic drain(input string tag);
        int g = 0;
        while ((sb.size() != 0 || busy) && g < 400) begin
            @(posedge clk1x);
            #1;
            g++;
        end
        check(tag, 64'(g < 400), 64'(1));
    endtask

    int n0, t_wr;

    initial begin
        reset = 1'b1; ioctl_download = 1'b0; ioctl_index = 8'd0; ioctl_addr = '0;
        ioctl_dout = '0; ioctl_wr = 1'b0; cfg_index = 8'd2; cfg_base = 27'h100000;
        cfg_swap = 2'd0;
        tick(3);
        check("rst_wr_req", 64'(wr_req), 64'(0));
        check("rst_wait",   64'(ioctl_wait), 64'(0));
        check("rst_busy",   64'(busy), 64'(0));
        check("rst_active", 64'(active), 64'(0));
        check("rst_loaded", 64'(loaded), 64'(0));
        check("rst_wr_data", 64'(wr_data), 64'(0));

        reset = 1'b0; ioctl_index = 8'd2; ioctl_download = 1'b1;
        tick(2);
        check("active_on", 64'(active), 64'(1));
        check("loaded_on", 64'(loaded), 64'(1));

        // Basic full word and pipeline latency
        io_wr(27'h0, 16'h1234);
        io_wr(27'h2, 16'h5678);
        t_wr = wr_cyc;
        sb.push_back(mk(27'h100000, 32'h56781234, 4'hF));
        drain("drain_basic");
        check("latency", 64'(req_cyc - t_wr), 64'(2));

        // Byte swap, then byte swap plus lane reversal
        cfg_swap = 2'd1;
        io_wr(27'h10, 16'h3C80);
        io_wr(27'h12, 16'h0F37);
        sb.push_back(mk(27'h100010, 32'h370F803C, 4'hF));
        drain("drain_swap1");
        cfg_swap = 2'd3;
        io_wr(27'h20, 16'h3C80);
        io_wr(27'h22, 16'h0F37);
        sb.push_back(mk(27'h100020, 32'h803C370F, 4'hF));
        drain("drain_swap3");
        cfg_swap = 2'd0;

        // Address add wraps modulo 2^ADDR_W
        cfg_base = 27'h7FFFFFC;
        io_wr(27'h8, 16'h1111);
        io_wr(27'hA, 16'h2222);
        sb.push_back(mk(27'h0000004, 32'h22221111, 4'hF));
        drain("drain_wrap");
        cfg_base = 27'h100000;

        // Key change with partial pending, new lane is the last one
        io_wr(27'h40, 16'hBEEF);
        io_wr(27'h46, 16'hCAFE);
        check("defer_wait", 64'(ioctl_wait), 64'(1));
        sb.push_back(mk(27'h100040, 32'h0000BEEF, 4'h3));
        sb.push_back(mk(27'h100044, 32'hCAFE0000, 4'hC));
        drain("drain_keychg");

        // Partial flush when download ends
        io_wr(27'h4, 16'hAAAA);
        ioctl_download = 1'b0;
        sb.push_back(mk(27'h100004, 32'h0000AAAA, 4'h3));
        drain("drain_flush");
        check("active_off", 64'(active), 64'(0));
        check("loaded_sticky", 64'(loaded), 64'(1));
        ioctl_download = 1'b1;
        tick(2);

        // Backpressure: withhold wr_done, then release every 5 cycles
        hold = 1'b1; done_dly = 4; wait_seen = 1'b0; n0 = n_req;
        fork
            begin
                for (int i = 0; i < 10; i++)
                    write_pair(ADDR_W'(32'h200 + 4 * i), 16'(16'h1000 + i), 16'(16'h2000 + i));
            end
            begin
                tick(40);
                hold = 1'b0;
            end
        join
        drain("drain_bp");
        check("bp_wait_seen", 64'(wait_seen), 64'(1));
        check("bp_count", 64'(n_req - n0), 64'(10));
        done_dly = 0;

        // Reset mid-burst: 1 outstanding, 2 queued
        hold = 1'b1;
        for (int i = 0; i < 3; i++)
            write_pair(ADDR_W'(32'h300 + 4 * i), 16'(16'h3000 + i), 16'(16'h4000 + i));
        tick(3);
        check("pre_rst_busy", 64'(busy), 64'(1));
        reset = 1'b1; ioctl_download = 1'b0;
        tick(1);
        check("mid_rst_wr_req", 64'(wr_req), 64'(0));
        check("mid_rst_wait",   64'(ioctl_wait), 64'(0));
        check("mid_rst_busy",   64'(busy), 64'(0));
        check("mid_rst_loaded", 64'(loaded), 64'(0));
        reset = 1'b0;
        sb.delete();
        n0 = n_req;
        hold = 1'b0;
        tick(10);
        check("late_done_req", 64'(n_req - n0), 64'(0));
        check("late_done_busy", 64'(busy), 64'(0));

        // Index mismatch: nothing accepted
        cfg_index = 8'd1; ioctl_index = 8'd0; ioctl_download = 1'b1;
        tick(3);
        n0 = n_req;
        io_wr(27'h0, 16'h1111);
        io_wr(27'h2, 16'h2222);
        tick(6);
        check("mm_active", 64'(active), 64'(0));
        check("mm_loaded", 64'(loaded), 64'(0));
        check("mm_busy",   64'(busy), 64'(0));
        check("mm_req",    64'(n_req - n0), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
